// File: rtl/arb_pkg.sv
// Shared types, mode constants and width helpers for the round-robin arbiter.
// Latency: none (package only).
// Backpressure: not applicable.
package arb_pkg;

  // Arbiter control states: nothing granted, or one requester owns the resource.
  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  // Arbitration modes.
  localparam int MODE_FIXED = 0;  // lowest index always wins
  localparam int MODE_RR    = 1;  // search starts at the rotating pointer

  // Index width for a given requester count; a single requester still needs one bit.
  function automatic int calc_idx_w(input int n_req);
    return (n_req > 1) ? $clog2(n_req) : 1;
  endfunction

  // Hold counter width; unlimited hold (0) keeps a 1-bit counter so nothing is zero-width.
  function automatic int calc_hold_w(input int max_hold);
    return (max_hold > 0) ? $clog2(max_hold + 1) : 1;
  endfunction

endpackage

// File: rtl/rr_mask_encoder.sv
// Rotated first-set search: finds the first asserted req bit scanning from start, wrapping mod N_REQ.
// Latency: purely combinational.
// Backpressure: none; the caller decides when the result is used.
module rr_mask_encoder
  import arb_pkg::*;
#(
  parameter  int N_REQ = 8,
  localparam int IDX_W = calc_idx_w(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] start,
  output logic             hit,
  output logic [IDX_W-1:0] idx
);

  // Walk start, start+1, ... wrapping at N_REQ (not 2^IDX_W); stop on the first hit.
  always_comb begin
    int               sum;
    logic [IDX_W-1:0] cand;
    hit  = 1'b0;
    idx  = '0;
    sum  = 0;
    cand = '0;
    for (int i = 0; i < N_REQ; i++) begin
      sum = int'(start) + i;
      if (sum >= N_REQ) begin
        sum = sum - N_REQ;
      end
      cand = IDX_W'(sum);
      if (req[cand]) begin
        hit = 1'b1;
        idx = cand;
        break;
      end
    end
  end

endmodule

// File: rtl/rr_priority_arbiter.sv
// Registered N_REQ-way arbiter (fixed or round-robin) with per-grant beat limit and back-to-back regrant.
// Latency: 1 cycle from req to gnt_valid; a released grant is replaced at the same edge when others wait.
// Backpressure: beats only count when gnt_ready is high; a stalled grant holds until beat/limit or withdrawal.
module rr_priority_arbiter
  import arb_pkg::*;
#(
  parameter  int N_REQ    = 8,
  parameter  int MODE     = 1,
  parameter  int MAX_HOLD = 4,
  localparam int IDX_W    = calc_idx_w(N_REQ)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  input  logic             req_last,
  input  logic             gnt_ready,
  output logic             gnt_valid,
  output logic [N_REQ-1:0] gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic [IDX_W-1:0] ptr
);

  localparam int HOLD_W = calc_hold_w(MAX_HOLD);
  // Saturation point of the hold counter; with unlimited hold it simply pins at all-ones.
  localparam logic [HOLD_W-1:0] HOLD_SAT = (MAX_HOLD > 0) ? HOLD_W'(MAX_HOLD) : {HOLD_W{1'b1}};

  arb_state_t       state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [HOLD_W-1:0] hold_q, hold_d;

  logic [IDX_W-1:0]  enc_start;
  logic              enc_hit;
  logic [IDX_W-1:0]  enc_idx;
  logic [IDX_W-1:0]  rel_ptr;
  logic [HOLD_W-1:0] hold_inc;
  logic              beat;
  logic              hit_limit;
  logic              rel_now;

  // Next index modulo N_REQ, so non-power-of-two sizes wrap to 0 instead of running past the end.
  function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] i);
    if (int'(i) >= N_REQ - 1) begin
      return '0;
    end
    return i + IDX_W'(1);
  endfunction

  // One search engine serves both the idle grant and the back-to-back regrant; only its start differs.
  rr_mask_encoder #(
    .N_REQ (N_REQ)
  ) u_enc (
    .req   (req),
    .start (enc_start),
    .hit   (enc_hit),
    .idx   (enc_idx)
  );

  // Pointer a release would install: one past the released requester in RR, always 0 in fixed mode.
  always_comb begin
    rel_ptr = '0;
    if (MODE == MODE_RR) begin
      rel_ptr = wrap_inc(idx_q);
    end
  end

  // Next-state, grant index, pointer and hold counter; a release reloads from the updated pointer.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    ptr_d     = ptr_q;
    hold_d    = hold_q;
    enc_start = ptr_q;
    beat      = 1'b0;
    hold_inc  = hold_q;
    hit_limit = 1'b0;
    rel_now   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (enc_hit) begin
          state_d = GRANT;
          idx_d   = enc_idx;
          hold_d  = '0;
        end
      end

      GRANT: begin
        beat      = gnt_ready;
        hold_inc  = (hold_q == HOLD_SAT) ? hold_q : hold_q + HOLD_W'(1);
        hit_limit = (MAX_HOLD != 0) && (hold_inc == HOLD_SAT);
        // A stalled grant is only abandoned if its owner stops requesting.
        rel_now   = beat ? (req_last || hit_limit) : !req[idx_q];

        if (rel_now) begin
          ptr_d     = rel_ptr;
          hold_d    = '0;
          enc_start = rel_ptr;
          if (enc_hit) begin
            idx_d = enc_idx;
          end else begin
            state_d = IDLE;
            idx_d   = '0;
          end
        end else if (beat) begin
          hold_d = hold_inc;
        end
      end

      default: begin
        state_d = IDLE;
        idx_d   = '0;
        hold_d  = '0;
      end
    endcase
  end

  // State register; reset drops any live grant without advancing the pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      ptr_q   <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      ptr_q   <= ptr_d;
      hold_q  <= hold_d;
    end
  end

  // One-hot grant decoded from the registered index; all-zero while idle.
  always_comb begin
    gnt = '0;
    if (state_q == GRANT) begin
      gnt[idx_q] = 1'b1;
    end
  end

  assign gnt_valid = (state_q == GRANT);
  assign gnt_idx   = idx_q;
  assign ptr       = ptr_q;

`ifndef SYNTHESIS
  a_gnt_onehot0 : assert property (@(posedge clk) disable iff (rst) $onehot0(gnt));
  a_gnt_idx_consistent : assert property (@(posedge clk) disable iff (rst) gnt[gnt_idx] == gnt_valid);
`endif

endmodule

// File: tb/tb_rr_priority_arbiter.sv
// Drives three arbiter configurations in lockstep and compares them against a behavioural model.
// Latency: model advances on each rising edge; outputs are compared on the following falling edge.
// Backpressure: gnt_ready is driven directly by the bench, both in directed phases and at random.
module tb_rr_priority_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [7:0] r0;
  logic [4:0] r1;
  logic [2:0] r2;
  logic       l0, l1, l2;
  logic       y0, y1, y2;

  logic       v0, v1, v2;
  logic [7:0] g0;
  logic [4:0] g1;
  logic [2:0] g2;
  logic [2:0] i0, p0;
  logic [2:0] i1, p1;
  logic [1:0] i2, p2;

  // u0: 8-way round-robin, 4-beat limit
  rr_priority_arbiter #(.N_REQ(8), .MODE(1), .MAX_HOLD(4)) u0 (
    .clk(clk), .rst(rst), .req(r0), .req_last(l0), .gnt_ready(y0),
    .gnt_valid(v0), .gnt(g0), .gnt_idx(i0), .ptr(p0)
  );
  // u1: 5-way round-robin, unlimited hold
  rr_priority_arbiter #(.N_REQ(5), .MODE(1), .MAX_HOLD(0)) u1 (
    .clk(clk), .rst(rst), .req(r1), .req_last(l1), .gnt_ready(y1),
    .gnt_valid(v1), .gnt(g1), .gnt_idx(i1), .ptr(p1)
  );
  // u2: 3-way fixed priority, 2-beat limit
  rr_priority_arbiter #(.N_REQ(3), .MODE(0), .MAX_HOLD(2)) u2 (
    .clk(clk), .rst(rst), .req(r2), .req_last(l2), .gnt_ready(y2),
    .gnt_valid(v2), .gnt(g2), .gnt_idx(i2), .ptr(p2)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Model state per instance: is a grant live, who owns it, search start, beats taken.
  int m_valid[3];
  int m_idx[3];
  int m_ptr[3];
  int m_hold[3];

  int e_idx[5] = '{0, 2, 7, 0, 2};
  int e_ptr[5] = '{0, 1, 3, 0, 1};

  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // First requester found scanning start, start+1, ... modulo n; -1 if none.
  function automatic int first_hit(input logic [7:0] r, input int start, input int n);
    for (int j = 0; j < n; j++) begin
      int c;
      c = (start + j) % n;
      if (((r >> c) & 8'h01) != 8'h00) return c;
    end
    return -1;
  endfunction

  task automatic model_step(input int k, input int n, input int mode, input int maxh,
                            input logic [7:0] r, input logic last, input logic rdy);
    bit rel;
    int cnt;
    if (rst) begin
      m_valid[k] = 0; m_idx[k] = 0; m_ptr[k] = 0; m_hold[k] = 0;
      return;
    end
    if (m_valid[k] == 0) begin
      if (r != 8'h00) begin
        m_valid[k] = 1;
        m_idx[k]   = first_hit(r, m_ptr[k], n);
        m_hold[k]  = 0;
      end
    end else begin
      rel = 1'b0;
      cnt = m_hold[k];
      if (rdy) begin
        cnt++;
        if (last) rel = 1'b1;
        if (maxh != 0 && cnt == maxh) rel = 1'b1;
      end else if (((r >> m_idx[k]) & 8'h01) == 8'h00) begin
        rel = 1'b1;
      end
      if (rel) begin
        m_ptr[k]  = (mode == 1) ? (m_idx[k] + 1) % n : 0;
        m_hold[k] = 0;
        if (r != 8'h00) begin
          m_idx[k] = first_hit(r, m_ptr[k], n);
        end else begin
          m_valid[k] = 0;
          m_idx[k]   = 0;
        end
      end else begin
        m_hold[k] = cnt;
      end
    end
  endtask

  task automatic check_inst(input int k, input string name, input int gv, input int g,
                            input int gi, input int p);
    int exp_g;
    exp_g = (m_valid[k] != 0) ? (1 << m_idx[k]) : 0;
    chk({name, ".gnt_valid"}, gv, m_valid[k]);
    chk({name, ".gnt"}, g, exp_g);
    chk({name, ".gnt_idx"}, gi, m_idx[k]);
    chk({name, ".ptr"}, p, m_ptr[k]);
  endtask

  // One clock: model consumes the inputs at the rising edge, outputs compared at the falling edge.
  task automatic step();
    @(posedge clk);
    model_step(0, 8, 1, 4, r0, l0, y0);
    model_step(1, 5, 1, 0, {3'b000, r1}, l1, y1);
    model_step(2, 3, 0, 2, {5'b00000, r2}, l2, y2);
    @(negedge clk);
    check_inst(0, "u0", int'(v0), int'(g0), int'(i0), int'(p0));
    check_inst(1, "u1", int'(v1), int'(g1), int'(i1), int'(p1));
    check_inst(2, "u2", int'(v2), int'(g2), int'(i2), int'(p2));
  endtask

  task automatic clear_inputs();
    r0 = '0; r1 = '0; r2 = '0;
    l0 = 1'b0; l1 = 1'b0; l2 = 1'b0;
    y0 = 1'b0; y1 = 1'b0; y2 = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  initial begin
    for (int k = 0; k < 3; k++) begin
      m_valid[k] = 0; m_idx[k] = 0; m_ptr[k] = 0; m_hold[k] = 0;
    end
    rst = 1'b1;
    clear_inputs();
    @(negedge clk);
    step();
    step();
    chk("reset.gnt_valid", int'(v0), 0);
    chk("reset.gnt", int'(g0), 0);
    chk("reset.gnt_idx", int'(i0), 0);
    chk("reset.ptr", int'(p0), 0);
    rst = 1'b0;

    // 8-way RR, req 1000_0101, single-beat grants: 0,2,7,0,2 with ptr 0,1,3,0,1
    r0 = 8'b1000_0101; l0 = 1'b1; y0 = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      chk("rr8.gnt_idx", int'(i0), e_idx[k]);
      chk("rr8.ptr", int'(p0), e_ptr[k]);
    end

    // 5-way RR, all requesting, single beats: 0..4 then 0 with no bubble
    do_reset();
    r1 = 5'b11111; l1 = 1'b1; y1 = 1'b1;
    for (int k = 0; k < 6; k++) begin
      step();
      chk("rr5.gnt_valid", int'(v1), 1);
      chk("rr5.gnt_idx", int'(i1), k % 5);
      chk("rr5.ptr", int'(p1), k % 5);
    end

    // Hold limit: requester 3 streams non-last beats, requester 5 waits
    do_reset();
    r0 = 8'b0010_1000; l0 = 1'b0; y0 = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      chk("hold.gnt_idx", int'(i0), 3);
    end
    step();
    chk("hold.moved_idx", int'(i0), 5);
    chk("hold.moved_ptr", int'(p0), 4);

    // Fixed priority: requester 1 keeps its grant although 0 arrives, then 0 wins, ptr stays 0
    do_reset();
    r2 = 3'b110;
    step();
    chk("fixed.first_idx", int'(i2), 1);
    r2 = 3'b111;
    step();
    chk("fixed.held_idx", int'(i2), 1);
    l2 = 1'b1; y2 = 1'b1;
    step();
    chk("fixed.next_idx", int'(i2), 0);
    chk("fixed.ptr", int'(p2), 0);
    chk("fixed.gnt_valid", int'(v2), 1);

    // Withdrawal without a beat: requester 2 drops out, nothing else waiting
    do_reset();
    r0 = 8'b0000_0100;
    step();
    chk("wd.gnt_idx", int'(i0), 2);
    r0 = 8'h00;
    step();
    chk("wd.gnt_valid", int'(v0), 0);
    chk("wd.ptr", int'(p0), 3);
    chk("wd.gnt_idx", int'(i0), 0);

    // Reset in the middle of a grant with a beat pending
    do_reset();
    r0 = 8'b1000_0100; y0 = 1'b1;
    step();
    chk("rstmid.pre_idx", int'(i0), 2);
    rst = 1'b1;
    step();
    chk("rstmid.gnt_valid", int'(v0), 0);
    chk("rstmid.gnt", int'(g0), 0);
    chk("rstmid.gnt_idx", int'(i0), 0);
    chk("rstmid.ptr", int'(p0), 0);
    rst = 1'b0;
    r0 = 8'b1000_0101;
    step();
    chk("rstmid.regrant_valid", int'(v0), 1);
    chk("rstmid.regrant_idx", int'(i0), 0);

    // Random traffic on all three instances, with occasional resets
    clear_inputs();
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 3) == 0) r0 = 8'($urandom);
      if ($urandom_range(0, 3) == 0) r1 = 5'($urandom);
      if ($urandom_range(0, 3) == 0) r2 = 3'($urandom);
      l0 = ($urandom_range(0, 3) == 0);
      l1 = ($urandom_range(0, 3) == 0);
      l2 = ($urandom_range(0, 3) == 0);
      y0 = ($urandom_range(0, 2) != 0);
      y1 = ($urandom_range(0, 2) != 0);
      y2 = ($urandom_range(0, 2) != 0);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/rr_priority_arbiter.md
Name: rr_priority_arbiter

Overview:
Parametrised, registered successor to the combinational priority encoder. Arbitrates N_REQ requesters and presents one grant at a time, as one-hot plus binary index, through a valid/ready handshake. Supports fixed-priority or round-robin mode, with optional grant hold across multi-beat transfers. Sits in front of shared resources such as a bus master port or a memory bank.

Parameters:
N_REQ, 8, number of requesters; must be >= 1, and non-power-of-two values are legal.
MODE, 1, 0 = fixed priority (lowest index wins); 1 = round-robin (search starts at ptr).
MAX_HOLD, 4, maximum handshaked beats per grant before forced release; 0 = unlimited.
IDX_W, (N_REQ>1 ? $clog2(N_REQ) : 1), derived index width; not user-overridden.

Ports:
clk  input  1  clock
rst  input  1  reset; synchronous, active-high
req  input  N_REQ  request vector; bit i = requester i wants the resource
req_last  input  1  qualifies the current beat from the granted requester as the final beat
gnt_ready  input  1  downstream accepts the current beat
gnt_valid  output  1  grant active
gnt  output  N_REQ  one-hot grant; zero when gnt_valid=0
gnt_idx  output  IDX_W  binary index of the granted requester; 0 when idle
ptr  output  IDX_W  round-robin start pointer (debug/visibility)

Behaviour:
- Reset is synchronous and active-high on clk. Registered outputs after reset: gnt_valid=0, gnt=0, gnt_idx=0, ptr=0, hold counter=0, state=IDLE. If rst is asserted mid-grant, the grant is dropped at that edge, and no release side effects (ptr advance) occur.
- FSM has two states: IDLE and GRANT.
- Winner selection:
  - Search order is ptr, ptr+1, … N_REQ-1, 0, … ptr-1 (MODE=1), or 0 … N_REQ-1 (MODE=0).
  - The first set req bit wins, i.e. the search breaks on the first hit.
  - Index arithmetic wraps modulo N_REQ, not 2^IDX_W.
- IDLE: if |req, go to GRANT next edge with gnt/gnt_idx = winner. Latency is 1 cycle from req to gnt_valid. If req=0, stay in IDLE.
- GRANT: gnt_valid=1. A beat is the condition gnt_valid & gnt_ready.
- Release occurs on any of the following:
  - a beat with req_last=1;
  - a beat that makes the hold count equal MAX_HOLD (when MAX_HOLD != 0);
  - req[gnt_idx]=0 while no beat occurs in that cycle (requester withdrew).
- On release:
  - ptr <= (gnt_idx+1) mod N_REQ in MODE=1; ptr stays 0 in MODE=0.
  - The hold counter clears.
  - If any req remains (evaluated with the updated search start), the next grant is loaded at the same edge: back-to-back, with no idle bubble.
  - Otherwise the FSM goes to IDLE.
- While held, gnt and gnt_idx are stable and req changes on other bits are ignored.
- The hold counter increments per beat and saturates; its width is $clog2(MAX_HOLD+1).
- N_REQ=1: ptr is always 0 and gnt_idx is always 0. Grant/release still follow the rules above.
- gnt is always one-hot or zero, and gnt[gnt_idx]==gnt_valid. Assertions on both are required in RTL.

Decomposition:
- Package arb_pkg holds:
  - arb_state_t enum {IDLE, GRANT};
  - MODE_FIXED=0 and MODE_RR=1 constants;
  - a function computing IDX_W from N_REQ.
- Sub-module rr_mask_encoder (combinational): inputs req and start; outputs hit and idx. Implements the rotated first-set search with a loop-and-break. It is reused by the FSM for both the IDLE and back-to-back paths.

Test Plan:
- MODE=1, N_REQ=8, req=8'b1000_0101, each grant ends with a req_last beat → grants are idx 0, 2, 7, then 0 again; ptr sequence is 1, 3, 0, 1.
- N_REQ=5, MODE=1, req=5'b11111 held, single-beat req_last each cycle → gnt_idx cycles 0,1,2,3,4,0 with no bubble; ptr wraps 4→0.
- MAX_HOLD=4, requester 3 streams beats with req_last=0 and gnt_ready=1, req[5] also set → exactly 4 beats granted to 3, then grant moves to 5 on the next cycle.
- MODE=0, N_REQ=3, req=3'b110, then req[0] set mid-transfer → requester 1 keeps its grant until req_last; the next grant is idx 0 and ptr stays 0.
- Granted requester 2 drops req with gnt_ready=0 → release at the next edge; gnt_valid=0 if no other requests, ptr=3.
- rst=1 asserted during GRANT with a beat pending → next edge gives gnt_valid=0, gnt=0, gnt_idx=0, ptr=0; req held high re-grants idx 0 one cycle after rst deasserts.
